load_result_queue: RTL and testbench

LOAD_RESULT_QUEUE -- requirements
Module: load_result_queue

---
 rtl/datapath_pkg.sv | 11 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/load_result_queue.sv | 102 ++++++++++
 tb/tb_load_result_queue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath types and the default depth of the load result queue.
package datapath_pkg;

  localparam int unsigned LRQ_DEPTH = 4;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned REGBITS_W = 5;

  typedef logic [WORD_W-1:0]    word_t;
  typedef logic [REGBITS_W-1:0] regbits_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised synchronous FIFO with an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/load_result_queue.sv
// In-order load result queue: tags wait for memory responses, results wait for writeback.
// Optional same-cycle response bypass: define LOAD_RESULT_QUEUE_BYPASS_EN.
module load_result_queue
  import datapath_pkg::*;
#(
  parameter int unsigned DEPTH  = LRQ_DEPTH,
  parameter int unsigned REG_W  = $bits(regbits_t),
  parameter int unsigned DATA_W = $bits(word_t)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     issue_valid,
  input  logic [REG_W-1:0]         issue_rd,
  output logic                     issue_ready,
  input  logic                     dmem_valid,
  input  logic [DATA_W-1:0]        dmem_rdata,
  output logic                     load_ready,
  output logic [REG_W-1:0]         reg_sel_load,
  output logic [DATA_W-1:0]        dmemload,
  input  logic                     load_done,
  output logic [$clog2(DEPTH):0]   in_flight,
  output logic                     err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic              issue_acc;
  logic              tag_empty;
  logic [REG_W-1:0]  tag_head;
  logic              resp_ok;
  logic              res_push;
  logic              res_pop;
  logic              res_empty;
  logic [REG_W-1:0]  res_rd;
  logic [DATA_W-1:0] res_data;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;
  logic              consume;
  logic              err_set;

  assign issue_ready = (in_flight < CW'(DEPTH));
  assign issue_acc   = issue_valid && issue_ready;
  assign resp_ok     = dmem_valid && !tag_empty;
  assign res_pop     = load_done && !res_empty;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(REG_W)) u_tag_fifo (
    .clk   (CLK),
    .rst   (nRST),
    .push  (issue_acc),
    .wdata (issue_rd),
    .pop   (resp_ok),
    .rdata (tag_head),
    .empty (tag_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(REG_W + DATA_W)) u_res_fifo (
    .clk   (CLK),
    .rst   (nRST),
    .push  (res_push),
    .wdata ({tag_head, dmem_rdata}),
    .pop   (res_pop),
    .rdata ({res_rd, res_data}),
    .empty (res_empty)
  );

`ifdef LOAD_RESULT_QUEUE_BYPASS_EN
  logic bypass_hit;

  // A response arriving at an empty result FIFO is presented directly; if it is
  // consumed in that cycle it never enters the FIFO.
  assign bypass_hit = res_empty && resp_ok;
  assign load_ready = !res_empty || bypass_hit;
  assign res_push   = resp_ok && !(bypass_hit && load_done);
  assign head_rd    = res_empty ? tag_head   : res_rd;
  assign head_data  = res_empty ? dmem_rdata : res_data;
`else
  assign load_ready = !res_empty;
  assign res_push   = resp_ok;
  assign head_rd    = res_rd;
  assign head_data  = res_data;
`endif

  assign reg_sel_load = load_ready ? head_rd   : '0;
  assign dmemload     = load_ready ? head_data : '0;
  assign consume      = load_done && load_ready;
  assign err_set      = (dmem_valid && tag_empty) || (load_done && !load_ready);

  always_ff @(posedge CLK) begin
    if (nRST) begin
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      case ({issue_acc, consume})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_result_queue.sv
// Directed self-checking bench for load_result_queue (DEPTH=4, REG_W=5, DATA_W=32).
module tb_load_result_queue;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        dmem_valid;
  logic [31:0] dmem_rdata;
  logic        load_ready;
  logic [4:0]  reg_sel_load;
  logic [31:0] dmemload;
  logic        load_done;
  logic [2:0]  in_flight;
  logic        err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  load_result_queue #(.DEPTH(4), .REG_W(5), .DATA_W(32)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .issue_ready  (issue_ready),
    .dmem_valid   (dmem_valid),
    .dmem_rdata   (dmem_rdata),
    .load_ready   (load_ready),
    .reg_sel_load (reg_sel_load),
    .dmemload     (dmemload),
    .load_done    (load_done),
    .in_flight    (in_flight),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // sample at the falling edge, well away from the active edge
  task automatic settle();
    @(negedge CLK);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_rd    = '0;
    dmem_valid  = 1'b0;
    dmem_rdata  = '0;
    load_done   = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    nRST = 1'b1;
    tick();
    tick();
    nRST = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    settle();
    check({tag, "_inflight"}, 64'(in_flight),    64'd0);
    check({tag, "_iready"},   64'(issue_ready),  64'd1);
    check({tag, "_lready"},   64'(load_ready),   64'd0);
    check({tag, "_rd"},       64'(reg_sel_load), 64'd0);
    check({tag, "_data"},     64'(dmemload),     64'd0);
    check({tag, "_err"},      64'(err),          64'd0);
  endtask

  initial begin
    idle();
    nRST = 1'b1;
    tick();
    // outputs forced while reset is held
    settle();
    check("rst_hold_lready", 64'(load_ready), 64'd0);
    check("rst_hold_iready", 64'(issue_ready), 64'd1);
    #1;
    do_reset();
    check_zero("reset");

    // single load: issue rd=3, respond next cycle, consume
    tick();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    idle();
    dmem_valid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    settle();
    check("s1_inflight", 64'(in_flight), 64'd1);
`ifdef LOAD_RESULT_QUEUE_BYPASS_EN
    check("s1_resp_cycle_lready", 64'(load_ready), 64'd1);
`else
    check("s1_resp_cycle_lready", 64'(load_ready), 64'd0);
`endif
    tick();
    idle();
    settle();
    check("s1_lready", 64'(load_ready),   64'd1);
    check("s1_rd",     64'(reg_sel_load), 64'd3);
    check("s1_data",   64'(dmemload),     64'hDEADBEEF);
    #1;
    load_done = 1'b1;
    tick();
    idle();
    settle();
    check("s1_done_lready",   64'(load_ready), 64'd0);
    check("s1_done_inflight", 64'(in_flight),  64'd0);
    check("s1_err",           64'(err),        64'd0);

    // fill: four back-to-back issues, fifth is held off
    tick();
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(i);
      tick();
    end
    issue_rd = 5'd5;
    settle();
    check("s2_full_iready",   64'(issue_ready), 64'd0);
    check("s2_full_inflight", 64'(in_flight),   64'd4);
    tick();
    settle();
    check("s2_no5th_inflight", 64'(in_flight), 64'd4);
    #1;
    idle();

    // four responses with writeback stalled
    for (int i = 1; i <= 4; i++) begin
      dmem_valid = 1'b1; dmem_rdata = 32'(i * 'h11);
      tick();
    end
    idle();
    tick();
    tick();
    settle();
    check("s3_head_rd",   64'(reg_sel_load), 64'd1);
    check("s3_head_data", 64'(dmemload),     64'h11);
    check("s3_iready",    64'(issue_ready),  64'd0);
    #1;
    load_done = 1'b1;
    tick();
    idle();
    settle();
    check("s2_after_pop_iready", 64'(issue_ready), 64'd1);
    check("s2_after_pop_inflight", 64'(in_flight), 64'd3);
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("s3_pop%0d_rd", i),   64'(reg_sel_load), 64'(i));
      check($sformatf("s3_pop%0d_data", i), 64'(dmemload),     64'(i * 'h11));
      #1;
      load_done = 1'b1;
      tick();
      idle();
      settle();
    end
    check("s3_empty_lready", 64'(load_ready), 64'd0);
    check("s3_err",          64'(err),        64'd0);

    // one result queued; push and pop together
    #1;
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_rd = 5'd8;
    tick();
    idle();
    dmem_valid = 1'b1; dmem_rdata = 32'h77;
    tick();
    dmem_valid = 1'b1; dmem_rdata = 32'h88; load_done = 1'b1;
    settle();
    check("s4_pre_lready", 64'(load_ready),   64'd1);
    check("s4_pre_rd",     64'(reg_sel_load), 64'd7);
    tick();
    idle();
    settle();
    check("s4_lready",   64'(load_ready),   64'd1);
    check("s4_rd",       64'(reg_sel_load), 64'd8);
    check("s4_data",     64'(dmemload),     64'h88);
    check("s4_inflight", 64'(in_flight),    64'd1);
    #1;
    load_done = 1'b1;
    tick();
    idle();
    settle();
    check("s4_drained_lready", 64'(load_ready), 64'd0);
    check("s4_drained_inflight", 64'(in_flight), 64'd0);

    // stray response sets a sticky error
    #1;
    dmem_valid = 1'b1; dmem_rdata = 32'hBAD;
    tick();
    idle();
    settle();
    check("s5_err",    64'(err),        64'd1);
    check("s5_lready", 64'(load_ready), 64'd0);
    tick();
    tick();
    settle();
    check("s5_err_sticky", 64'(err), 64'd1);

    // reset mid-stream with three in flight (one result, two tags)
    #1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_rd = 5'(10 + i);
      tick();
    end
    idle();
    dmem_valid = 1'b1; dmem_rdata = 32'hCAFE;
    tick();
    idle();
    settle();
    check("s5_pre_inflight", 64'(in_flight), 64'd3);
    #1;
    nRST = 1'b1;
    tick();
    nRST = 1'b0;
    check_zero("s5_midrst");

    // response in the first cycle after reset has no tag
    #1;
    dmem_valid = 1'b1; dmem_rdata = 32'h1234;
    tick();
    idle();
    settle();
    check("s5_post_rst_err",    64'(err),        64'd1);
    check("s5_post_rst_lready", 64'(load_ready), 64'd0);

    // writeback with nothing ready is an error
    #1;
    do_reset();
    load_done = 1'b1;
    tick();
    idle();
    settle();
    check("s5_spurious_done_err", 64'(err), 64'd1);
    check("s5_spurious_done_inflight", 64'(in_flight), 64'd0);

`ifdef LOAD_RESULT_QUEUE_BYPASS_EN
    // same-cycle response and consume on an empty queue
    #1;
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    dmem_valid = 1'b1; dmem_rdata = 32'h99; load_done = 1'b1;
    settle();
    check("byp_lready", 64'(load_ready),   64'd1);
    check("byp_rd",     64'(reg_sel_load), 64'd9);
    check("byp_data",   64'(dmemload),     64'h99);
    tick();
    idle();
    settle();
    check("byp_after_lready",   64'(load_ready), 64'd0);
    check("byp_after_inflight", 64'(in_flight),  64'd0);
    check("byp_after_err",      64'(err),        64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
